// File: rtl/operand_loader_if.sv
// Operand loader bus: byte stream in, operand/strobe side out, FPU done back.
// Handshake: a byte moves on a rising clk edge where in_valid & in_ready are
// both high; the source holds in_valid/in_data stable until that edge, and
// in_ready depends only on loader state (never on in_valid).
// master = the loader itself, slave = the byte source / register / FPU side.
interface operand_loader_if #(
   parameter int SIZE = 32
);
   logic            in_valid;
   logic [7:0]      in_data;
   logic            in_ready;
   logic [SIZE-1:0] dout;
   logic            ld_a;
   logic            ld_b;
   logic            start;
   logic            fpu_done;
   logic            busy;
   logic            err;

   modport master (
      input  in_valid, in_data, fpu_done,
      output in_ready, dout, ld_a, ld_b, start, busy, err
   );

   modport slave (
      output in_valid, in_data, fpu_done,
      input  in_ready, dout, ld_a, ld_b, start, busy, err
   );
endinterface

// File: rtl/operand_loader.sv
// operand_loader: byte-serial front end that assembles operand A then B
// (MSB byte first), strobes ld_a/ld_b into the operand registers, pulses
// start and waits for fpu_done before taking the next pair.
// Optional macro LOADER_PARITY_EN: each operand is followed by an even-parity
// byte (bit 0 = XOR of all operand bits); a mismatch pulses err and drops
// the pair. Without the macro err is tied low.
// o_state exposes the FSM state encoding for debug/checkers.
module operand_loader #(
   parameter int SIZE = 32
) (
   input  logic              clk,
   input  logic              rst,
   operand_loader_if.master  io_bus,
   output logic [3:0]        o_state
);

   localparam int NB = SIZE / 8;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NB - 1);

`ifdef LOADER_PARITY_EN
   typedef enum logic [3:0] {
      S_LOAD_A  = 4'd0,
      S_LATCH_A = 4'd1,
      S_LOAD_B  = 4'd2,
      S_LATCH_B = 4'd3,
      S_START   = 4'd4,
      S_WAIT    = 4'd5,
      S_PAR_A   = 4'd6,
      S_PAR_B   = 4'd7,
      S_ERR     = 4'd8
   } state_t;
`else
   typedef enum logic [3:0] {
      S_LOAD_A  = 4'd0,
      S_LATCH_A = 4'd1,
      S_LOAD_B  = 4'd2,
      S_LATCH_B = 4'd3,
      S_START   = 4'd4,
      S_WAIT    = 4'd5
   } state_t;
`endif

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_cnt;
   logic [SIZE-1:0] r_dout;
   logic [SIZE-1:0] w_shift;
   logic            w_ready;
   logic            w_xfer;
   logic            w_load;
   logic            w_last;

   // Data bytes shift into dout only in the load states; parity bytes do not.
   assign w_load = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
`ifdef LOADER_PARITY_EN
   logic w_par_ok;
   assign w_ready  = w_load || (r_state == S_PAR_A) || (r_state == S_PAR_B);
   assign w_par_ok = ((^r_dout) == io_bus.in_data[0]);
`else
   assign w_ready  = w_load;
`endif
   assign w_xfer = io_bus.in_valid && w_ready;
   assign w_last = (r_cnt == LAST);

   generate
      if (SIZE == 8) begin : g_byte
         assign w_shift = io_bus.in_data;
      end else begin : g_wide
         assign w_shift = {r_dout[SIZE-9:0], io_bus.in_data};
      end
   endgenerate

   // State register; reset lands in LOAD_A and drops any partial operand.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_LOAD_A;
      end else begin
         r_state <= w_next;
      end
   end

   // Operand shift register and byte counter, advanced only on data transfers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dout <= '0;
         r_cnt  <= '0;
      end else if (w_xfer && w_load) begin
         r_dout <= w_shift;
         r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

   // Next-state decode; fpu_done is only looked at in WAIT.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_LOAD_A: begin
            if (io_bus.in_valid && w_last) begin
`ifdef LOADER_PARITY_EN
               w_next = S_PAR_A;
`else
               w_next = S_LATCH_A;
`endif
            end
         end
         S_LATCH_A: w_next = S_LOAD_B;
         S_LOAD_B: begin
            if (io_bus.in_valid && w_last) begin
`ifdef LOADER_PARITY_EN
               w_next = S_PAR_B;
`else
               w_next = S_LATCH_B;
`endif
            end
         end
         S_LATCH_B: w_next = S_START;
         S_START:   w_next = S_WAIT;
         S_WAIT: begin
            if (io_bus.fpu_done) begin
               w_next = S_LOAD_A;
            end
         end
`ifdef LOADER_PARITY_EN
         S_PAR_A: begin
            if (io_bus.in_valid) begin
               w_next = w_par_ok ? S_LATCH_A : S_ERR;
            end
         end
         S_PAR_B: begin
            if (io_bus.in_valid) begin
               w_next = w_par_ok ? S_LATCH_B : S_ERR;
            end
         end
         S_ERR:     w_next = S_LOAD_A;
`endif
         default:   w_next = S_LOAD_A;
      endcase
   end

   // Moore outputs decoded from state only.
   assign io_bus.in_ready = w_ready;
   assign io_bus.dout     = r_dout;
   assign io_bus.ld_a     = (r_state == S_LATCH_A);
   assign io_bus.ld_b     = (r_state == S_LATCH_B);
   assign io_bus.start    = (r_state == S_START);
   assign io_bus.busy     = (r_state == S_START) || (r_state == S_WAIT);
`ifdef LOADER_PARITY_EN
   assign io_bus.err      = (r_state == S_ERR);
`else
   assign io_bus.err      = 1'b0;
`endif
   assign o_state         = r_state;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: SIZE=32 and SIZE=16 instances on one
// clock. Inputs change on the falling edge, outputs are sampled there too.
// Define LOADER_PARITY_EN to also exercise the parity path.
module tb_operand_loader;

   localparam logic [3:0] ST_LOAD_A  = 4'd0;
   localparam logic [3:0] ST_LATCH_A = 4'd1;
   localparam logic [3:0] ST_LOAD_B  = 4'd2;
   localparam logic [3:0] ST_LATCH_B = 4'd3;
   localparam logic [3:0] ST_WAIT    = 4'd5;
   localparam logic [3:0] ST_ERR     = 4'd8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   operand_loader_if #(.SIZE(32)) bus32 ();
   operand_loader_if #(.SIZE(16)) bus16 ();
   logic [3:0] st32;
   logic [3:0] st16;

   operand_loader #(.SIZE(32)) dut32 (
      .clk     (clk),
      .rst     (rst),
      .io_bus  (bus32),
      .o_state (st32)
   );

   operand_loader #(.SIZE(16)) dut16 (
      .clk     (clk),
      .rst     (rst),
      .io_bus  (bus16),
      .o_state (st16)
   );

   // ---------------- scoreboard ----------------
   int n_chk = 0;
   int n_err = 0;
   logic [31:0] exp_a_q[$];
   logic [31:0] exp_b_q[$];
   logic [31:0] exp16_a_q[$];
   logic [31:0] exp16_b_q[$];
   int n_start32 = 0;
   int n_start16 = 0;
   int n_perr32  = 0;
   int exp_start32 = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Every strobe must carry the next expected operand.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus32.ld_a) begin
            if (exp_a_q.size() == 0) chk("ld_a32 unexpected", exp_a_q.size(), 1);
            else chk("ld_a32 dout", bus32.dout, exp_a_q.pop_front());
         end
         if (bus32.ld_b) begin
            if (exp_b_q.size() == 0) chk("ld_b32 unexpected", exp_b_q.size(), 1);
            else chk("ld_b32 dout", bus32.dout, exp_b_q.pop_front());
         end
         if (bus16.ld_a) begin
            if (exp16_a_q.size() == 0) chk("ld_a16 unexpected", exp16_a_q.size(), 1);
            else chk("ld_a16 dout", {16'h0, bus16.dout}, exp16_a_q.pop_front());
         end
         if (bus16.ld_b) begin
            if (exp16_b_q.size() == 0) chk("ld_b16 unexpected", exp16_b_q.size(), 1);
            else chk("ld_b16 dout", {16'h0, bus16.dout}, exp16_b_q.pop_front());
         end
         if (bus32.start) n_start32++;
         if (bus16.start) n_start16++;
         if (bus32.err)   n_perr32++;
      end
   end

   // ---------------- drivers ----------------
   task automatic send32(input logic [7:0] b);
      int t;
      bus32.in_valid = 1'b1;
      bus32.in_data  = b;
      t = 0;
      while (!bus32.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!bus32.in_ready) chk("send32 ready timeout", bus32.in_ready, 1);
      else begin
         @(posedge clk);
         @(negedge clk);
      end
      bus32.in_valid = 1'b0;
      bus32.in_data  = 8'h55;
   endtask

   task automatic send16(input logic [7:0] b);
      int t;
      bus16.in_valid = 1'b1;
      bus16.in_data  = b;
      t = 0;
      while (!bus16.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!bus16.in_ready) chk("send16 ready timeout", bus16.in_ready, 1);
      else begin
         @(posedge clk);
         @(negedge clk);
      end
      bus16.in_valid = 1'b0;
      bus16.in_data  = 8'h55;
   endtask

   // One operand, MSB byte first, optional idle gap (with junk on in_data)
   // between bytes, followed by its parity byte when parity is enabled.
   task automatic send_op32(input logic [31:0] v, input int gap);
      for (int i = 3; i >= 0; i--) begin
         send32(v[8*i +: 8]);
         if (gap > 0 && i > 0) repeat (gap) @(negedge clk);
      end
`ifdef LOADER_PARITY_EN
      send32({7'b0, ^v});
`endif
   endtask

   task automatic send_op16(input logic [15:0] v);
      send16(v[15:8]);
      send16(v[7:0]);
`ifdef LOADER_PARITY_EN
      send16({7'b0, ^v});
`endif
   endtask

   // Full A/B pair with strobe timing, busy window and fpu_done release.
   task automatic run_pair(input logic [31:0] a, input logic [31:0] b, input int gap);
      exp_a_q.push_back(a);
      exp_b_q.push_back(b);
      exp_start32++;
      send_op32(a, gap);
      chk("latch_a ld_a", bus32.ld_a, 1);
      chk("latch_a in_ready", bus32.in_ready, 0);
      chk("latch_a state", st32, ST_LATCH_A);
      @(negedge clk);
      chk("load_b ld_a", bus32.ld_a, 0);
      chk("load_b in_ready", bus32.in_ready, 1);
      send_op32(b, gap);
      chk("latch_b ld_b", bus32.ld_b, 1);
      chk("latch_b state", st32, ST_LATCH_B);
      chk("latch_b busy", bus32.busy, 0);
      @(negedge clk);
      chk("start pulse", bus32.start, 1);
      chk("start busy", bus32.busy, 1);
      @(negedge clk);
      chk("wait start low", bus32.start, 0);
      chk("wait busy", bus32.busy, 1);
      chk("wait in_ready", bus32.in_ready, 0);
      repeat (3) @(negedge clk);
      chk("wait hold state", st32, ST_WAIT);
      bus32.fpu_done = 1'b1;
      @(negedge clk);
      bus32.fpu_done = 1'b0;
      chk("done busy", bus32.busy, 0);
      chk("done in_ready", bus32.in_ready, 1);
      chk("done state", st32, ST_LOAD_A);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bus32.in_valid = 1'b0; bus32.in_data = 8'h00; bus32.fpu_done = 1'b0;
      bus16.in_valid = 1'b0; bus16.in_data = 8'h00; bus16.fpu_done = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // reset values
      chk("rst in_ready", bus32.in_ready, 1);
      chk("rst dout", bus32.dout, 32'h0);
      chk("rst ld_a", bus32.ld_a, 0);
      chk("rst ld_b", bus32.ld_b, 0);
      chk("rst start", bus32.start, 0);
      chk("rst busy", bus32.busy, 0);
      chk("rst err", bus32.err, 0);
      chk("rst state", st32, ST_LOAD_A);
      rst = 1'b0;
      @(negedge clk);

      // basic pair, back-to-back bytes
      run_pair(32'h3F80_0000, 32'h4000_0000, 0);

      // same pair with 3 idle cycles between every byte
      run_pair(32'h3F80_0000, 32'h4000_0000, 3);

      // backpressure: 0xAA offered from LATCH_B on, fpu_done during START
      exp_a_q.push_back(32'hC049_0FDB);
      exp_b_q.push_back(32'h1234_5678);
      exp_start32++;
      send_op32(32'hC049_0FDB, 0);
      @(negedge clk);
      send_op32(32'h1234_5678, 0);
      bus32.in_valid = 1'b1;
      bus32.in_data  = 8'hAA;
      @(negedge clk);
      chk("bp start", bus32.start, 1);
      bus32.fpu_done = 1'b1;
      @(negedge clk);
      bus32.fpu_done = 1'b0;
      chk("bp done-in-start ignored", st32, ST_WAIT);
      chk("bp wait in_ready", bus32.in_ready, 0);
      repeat (3) @(negedge clk);
      chk("bp still wait", st32, ST_WAIT);
      chk("bp dout held", bus32.dout, 32'h1234_5678);
      bus32.fpu_done = 1'b1;
      bus32.in_valid = 1'b0;
      @(negedge clk);
      bus32.fpu_done = 1'b0;
      chk("bp released", st32, ST_LOAD_A);
      chk("bp aa not taken", bus32.dout, 32'h1234_5678);

      // reset in the middle of operand B
      exp_a_q.push_back(32'h1122_3344);
      send_op32(32'h1122_3344, 0);
      @(negedge clk);
      send32(8'h55);
      send32(8'h66);
      chk("partial b dout", bus32.dout, 32'h3344_5566);
      rst = 1'b1;
      #1;
      chk("mid rst dout", bus32.dout, 32'h0);
      chk("mid rst in_ready", bus32.in_ready, 1);
      chk("mid rst ld_b", bus32.ld_b, 0);
      chk("mid rst busy", bus32.busy, 0);
      chk("mid rst state", st32, ST_LOAD_A);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_pair(32'hA1B2_C3D4, 32'h0102_0304, 0);

      // SIZE=16 instance
      exp16_a_q.push_back(32'h1234);
      exp16_b_q.push_back(32'h5678);
      send_op16(16'h1234);
      chk("s16 ld_a", bus16.ld_a, 1);
      @(negedge clk);
      send_op16(16'h5678);
      chk("s16 ld_b", bus16.ld_b, 1);
      @(negedge clk);
      chk("s16 start", bus16.start, 1);
      @(negedge clk);
      bus16.fpu_done = 1'b1;
      @(negedge clk);
      bus16.fpu_done = 1'b0;
      chk("s16 done state", st16, ST_LOAD_A);

`ifdef LOADER_PARITY_EN
      // good parity: A = 1 with parity byte 0x01
      run_pair(32'h0000_0001, 32'h0000_0003, 0);
      // bad parity: A = 1 with parity byte 0x00
      send32(8'h00); send32(8'h00); send32(8'h00); send32(8'h01);
      send32(8'h00);
      chk("perr err", bus32.err, 1);
      chk("perr ld_a", bus32.ld_a, 0);
      chk("perr state", st32, ST_ERR);
      @(negedge clk);
      chk("perr err low", bus32.err, 0);
      chk("perr back to load_a", st32, ST_LOAD_A);
      chk("perr in_ready", bus32.in_ready, 1);
      run_pair(32'h8000_0001, 32'h7F00_0000, 0);
      chk("parity err count", n_perr32, 1);
`else
      chk("parity err count", n_perr32, 0);
`endif

      @(negedge clk);
      chk("start count 32", n_start32, exp_start32);
      chk("start count 16", n_start16, 1);
      chk("exp_a left", exp_a_q.size(), 0);
      chk("exp_b left", exp_b_q.size(), 0);
      chk("exp16 left", exp16_a_q.size() + exp16_b_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/operand_loader.md
# operand_loader

Byte-serial operand front end for the FPU datapath. It accepts an 8-bit stream over a valid/ready handshake and assembles two SIZE-bit operands, A then B. It drives the `din`/`ld` side of the downstream operand registers, then pulses `start` and waits for the FPU to finish before accepting the next pair. It is the writer that feeds the team's generic load-enable register.

## Interface
- SIZE, 32, operand width in bits; must be a multiple of 8 and ≥ 8; NB = SIZE/8 bytes per operand
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  byte present on in_data
- in_data  in  8  stream byte, most-significant byte of each operand first
- in_ready  out  1  loader can accept a byte this cycle
- dout  out  SIZE  assembled operand; connect to `din` of both operand registers
- ld_a  out  1  one-cycle load strobe for operand A register
- ld_b  out  1  one-cycle load strobe for operand B register
- start  out  1  one-cycle FPU start pulse
- fpu_done  in  1  FPU completion; sampled only in WAIT
- busy  out  1  high from START through WAIT
- err  out  1  one-cycle parity error pulse; constant 0 without the macro

## Operation
- **Reset values:** all outputs 0, except in_ready = 1 because the reset state is LOAD_A.
  - dout = 0, byte counter = 0, state = LOAD_A.
  - Reset mid-operation discards any partial operand.
  - Strobes already issued are not undone.
- **Transfer rule:** a transfer occurs on a rising edge with in_valid & in_ready.
  - On each transfer, dout <= {dout[SIZE-9:0], in_data} and the counter increments.
  - The counter wraps to 0 on the NB-th byte.
- **in_ready:** combinational from state; 1 only in LOAD_A, LOAD_B (and PAR_A, PAR_B with the macro).
- **States:**
  - LOAD_A: accept NB bytes. The last byte moves to LATCH_A, or to PAR_A with the macro.
  - LATCH_A: ld_a = 1 for one cycle. dout is stable (no shift). Next state LOAD_B.
  - LOAD_B: accept NB bytes. The last byte moves to LATCH_B, or to PAR_B with the macro.
  - LATCH_B: ld_b = 1 for one cycle. Next state START.
  - START: start = 1, busy = 1 for one cycle. Next state WAIT.
  - WAIT: busy = 1, in_ready = 0. If fpu_done = 1, the next state is LOAD_A; otherwise stay.
- **Moore outputs:** ld_a, ld_b, start and busy are decoded from state only.
- **fpu_done outside WAIT** is ignored, including a done that is high during START.
- **Held in_valid:** bytes offered while in_ready = 0 are not consumed. The source must hold in_valid/in_data.
- **Input gaps:** gaps between bytes are allowed anywhere; there is no timeout.

## Timing
- The last A byte is accepted at edge k.
  - ld_a is high in cycle k..k+1.
  - The A register captures dout at edge k+1.
  - in_ready rises after edge k+1.
- With back-to-back B bytes, the last B byte is accepted at edge k+1+NB.
  - ld_b is high during the following cycle.
  - start is high one cycle after that.
  - busy stays high from the start cycle until the edge that samples fpu_done = 1.
- Minimum period per operand pair: 2·NB + 3 cycles, plus FPU latency. With the macro, add 2 cycles.
- in_data on a non-transfer cycle has no effect on dout.

## Configuration
- **LOADER_PARITY_EN defined:**
  - Each operand is followed by one parity byte. Bit 0 must equal the XOR of all SIZE operand bits (even parity); bits 7:1 are ignored.
  - PAR_A / PAR_B accept this byte without shifting dout.
  - On a match, go to LATCH_A / LATCH_B.
  - On a mismatch, err = 1 for the cycle after the parity byte (state ERR), then return to LOAD_A. No ld_a/ld_b/start is issued. An A already latched is superseded by the next pair.
- **Not defined:** PAR_A, PAR_B and ERR do not exist; err is tied to 0.

## Test plan
- **Basic pair, SIZE=32:**
  - Stimulus: bytes 3F 80 00 00 40 00 00 00, in_valid held high.
  - Required: ld_a with dout = 0x3F800000; ld_b with dout = 0x40000000; one start pulse; busy = 1 until fpu_done.
- **Input gaps:** same stream with in_valid low for 3 cycles between every byte. Required: identical dout values and strobes; the counter does not advance on gaps.
- **Backpressure and fpu_done masking:**
  - Stimulus: in_valid held high with 0xAA during LATCH_A/LATCH_B/START/WAIT; fpu_done pulsed during START.
  - Required: 0xAA is not consumed; the loader stays in WAIT until a later fpu_done.
- **Reset mid-operand:** assert rst after 2 bytes of B. Required: all outputs 0, in_ready = 1, dout = 0; the next 8 bytes form a fresh A/B pair.
- **SIZE=16:** bytes 12 34 56 78. Required: ld_a with dout = 0x1234, then ld_b with dout = 0x5678.
- **LOADER_PARITY_EN:**
  - A = 0x00000001 with parity byte 0x01: ld_a is issued.
  - A = 0x00000001 with parity byte 0x00: err pulse, no ld_a, state returns to LOAD_A.
